// File: rtl/clock_render_pkg.sv
// Shared types and constants for the analog-clock rendering path.
// Hand index and FSM encodings, default hand lengths and the angle reduction helpers.
package clock_render_pkg;

   localparam int ANGLE_W        = 9;
   localparam int CORDIC_ANGLE_W = 16;

   localparam int DEF_LEN_HR  = 23;
   localparam int DEF_LEN_MIN = 31;
   localparam int DEF_LEN_SEC = 27;
   localparam int DEF_LEN_AL  = 17;

   typedef enum logic [1:0] {
      HAND_HR  = 2'd0,
      HAND_MIN = 2'd1,
      HAND_SEC = 2'd2,
      HAND_AL  = 2'd3
   } hand_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_ISSUE,
      S_WAIT,
      S_EMIT,
      S_FINISH
   } state_e;

   // Out-of-range minute/second codes are pinned to the last tick of the dial.
   function automatic logic [5:0] clamp59(input logic [5:0] v);
      return (v > 6'd59) ? 6'd59 : v;
   endfunction

   function automatic logic [3:0] wrap12(input logic [3:0] h);
      return (h >= 4'd12) ? h - 4'd12 : h;
   endfunction

endpackage

// File: rtl/hand_angle_calc.sv
// Combinational conversion of a time/alarm snapshot into the four hand angles in degrees.
module hand_angle_calc
   import clock_render_pkg::*;
(
   input  logic [3:0] hour,
   input  logic [5:0] minute,
   input  logic [5:0] second,
   input  logic [3:0] al_hour,
   input  logic [5:0] al_minute,
   output logic [8:0] ang_hr,
   output logic [8:0] ang_min,
   output logic [8:0] ang_sec,
   output logic [8:0] ang_al
);

   logic [3:0] hr12;
   logic [3:0] al12;
   logic [5:0] min_c;
   logic [5:0] sec_c;
   logic [5:0] alm_c;
   logic [9:0] hr_total;

   // NOTE: every signal written here is assigned on every pass, so no latch is inferred.
   always_comb begin
      hr12     = wrap12(hour);
      al12     = wrap12(al_hour);
      min_c    = clamp59(minute);
      sec_c    = clamp59(second);
      alm_c    = clamp59(al_minute);
      // Hour hand advances half a degree per minute; the half is truncated.
      hr_total = 10'(hr12) * 10'd60 + 10'(min_c);
      ang_hr   = ANGLE_W'(hr_total >> 1);
      ang_min  = ANGLE_W'(min_c) * ANGLE_W'(6);
      ang_sec  = ANGLE_W'(sec_c) * ANGLE_W'(6);
      ang_al   = ANGLE_W'(al12) * ANGLE_W'(30) + ANGLE_W'(alm_c / 6'd10) * ANGLE_W'(6);
   end

endmodule

// File: rtl/clock_hand_scheduler.sv
// Frame sequencer: on each 1 Hz tick edge, clears the framebuffer, then runs the four
// hands through the shared CORDIC one at a time and hands each result to the plotter.
module clock_hand_scheduler
   import clock_render_pkg::*;
#(
   parameter int CORDIC_TIMEOUT = 64,
   parameter int LEN_HR         = DEF_LEN_HR,
   parameter int LEN_MIN        = DEF_LEN_MIN,
   parameter int LEN_SEC        = DEF_LEN_SEC,
   parameter int LEN_AL         = DEF_LEN_AL
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        slow_clk,
   input  logic [3:0]  hour,
   input  logic [5:0]  minute,
   input  logic [5:0]  second,
   input  logic [3:0]  al_hour,
   input  logic [5:0]  al_minute,
   output logic        cordic_start,
   output logic [15:0] cordic_angle,
   input  logic        cordic_done,
   input  logic [15:0] sin_in,
   input  logic [15:0] cos_in,
   output logic        clr_req,
   input  logic        clr_ack,
   output logic        job_valid,
   input  logic        job_ready,
   output logic [1:0]  job_hand,
   output logic [4:0]  job_len,
   output logic [15:0] job_sin,
   output logic [15:0] job_cos,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun,
   output logic        timeout_err
);

   localparam int CNT_W = ($clog2(CORDIC_TIMEOUT + 1) > 7) ? $clog2(CORDIC_TIMEOUT + 1) : 7;

   state_e             state;
   state_e             state_nx;
   hand_e              hand_idx;
   logic               slow_q;
   logic               trigger;
   logic               tmo_fire;
   logic               last_hand;
   logic [CNT_W-1:0]   tmo_cnt;
   logic [3:0]         snap_hour;
   logic [3:0]         snap_al_hour;
   logic [5:0]         snap_minute;
   logic [5:0]         snap_second;
   logic [5:0]         snap_al_minute;
   logic [15:0]        sin_q;
   logic [15:0]        cos_q;
   logic               overrun_q;
   logic               timeout_err_q;
   logic [8:0]         ang_hr;
   logic [8:0]         ang_min;
   logic [8:0]         ang_sec;
   logic [8:0]         ang_al;
   logic [8:0]         angle_sel;
   logic [4:0]         len_sel;

   assign trigger   = slow_clk & ~slow_q;
   assign last_hand = (hand_idx == HAND_AL);

   hand_angle_calc u_angles (
      .hour      (snap_hour),
      .minute    (snap_minute),
      .second    (snap_second),
      .al_hour   (snap_al_hour),
      .al_minute (snap_al_minute),
      .ang_hr    (ang_hr),
      .ang_min   (ang_min),
      .ang_sec   (ang_sec),
      .ang_al    (ang_al)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      tmo_fire     = 1'b0;
      angle_sel    = ang_hr;
      len_sel      = 5'(LEN_HR);
      busy         = (state != S_IDLE);
      clr_req      = 1'b0;
      cordic_start = 1'b0;
      cordic_angle = '0;
      job_valid    = 1'b0;
      job_hand     = 2'd0;
      job_len      = 5'd0;
      job_sin      = 16'd0;
      job_cos      = 16'd0;
      frame_done   = 1'b0;

      unique case (hand_idx)
         HAND_HR:  begin angle_sel = ang_hr;  len_sel = 5'(LEN_HR);  end
         HAND_MIN: begin angle_sel = ang_min; len_sel = 5'(LEN_MIN); end
         HAND_SEC: begin angle_sel = ang_sec; len_sel = 5'(LEN_SEC); end
         HAND_AL:  begin angle_sel = ang_al;  len_sel = 5'(LEN_AL);  end
         default:  ;
      endcase

      unique case (state)
         S_IDLE:  if (trigger) state_nx = S_CLEAR;
         S_CLEAR: begin
            clr_req = 1'b1;
            if (clr_ack) state_nx = S_ISSUE;
         end
         S_ISSUE: begin
            cordic_start = 1'b1;
            cordic_angle = CORDIC_ANGLE_W'(angle_sel);
            state_nx     = S_WAIT;
         end
         S_WAIT: begin
            cordic_angle = CORDIC_ANGLE_W'(angle_sel);
            if (cordic_done) begin
               state_nx = S_EMIT;
            end else if (tmo_cnt == CNT_W'(CORDIC_TIMEOUT)) begin
               tmo_fire = 1'b1;
               state_nx = last_hand ? S_FINISH : S_ISSUE;
            end
         end
         S_EMIT: begin
            job_valid = 1'b1;
            job_hand  = hand_idx;
            job_len   = len_sel;
            job_sin   = sin_q;
            job_cos   = cos_q;
            if (job_ready) state_nx = last_hand ? S_FINISH : S_ISSUE;
         end
         S_FINISH: begin
            frame_done = 1'b1;
            state_nx   = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   assign overrun     = overrun_q;
   assign timeout_err = timeout_err_q;

   // NOTE: non-blocking assignments so every register here samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // High so a tick already asserted when reset lifts is not mistaken for an edge.
         slow_q         <= 1'b1;
         hand_idx       <= HAND_HR;
         tmo_cnt        <= '0;
         snap_hour      <= '0;
         snap_minute    <= '0;
         snap_second    <= '0;
         snap_al_hour   <= '0;
         snap_al_minute <= '0;
         sin_q          <= '0;
         cos_q          <= '0;
         overrun_q      <= 1'b0;
         timeout_err_q  <= 1'b0;
      end else begin
         slow_q    <= slow_clk;
         overrun_q <= trigger && (state != S_IDLE);

         if (state == S_IDLE && trigger) begin
            snap_hour      <= hour;
            snap_minute    <= minute;
            snap_second    <= second;
            snap_al_hour   <= al_hour;
            snap_al_minute <= al_minute;
            hand_idx       <= HAND_HR;
         end

         // Counts cycles since cordic_start, so it reads CORDIC_TIMEOUT on the last allowed cycle.
         if (state == S_ISSUE)     tmo_cnt <= CNT_W'(1);
         else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;

         if (state == S_WAIT && cordic_done) begin
            sin_q <= sin_in;
            cos_q <= cos_in;
         end

         if (tmo_fire) timeout_err_q <= 1'b1;

         if ((tmo_fire || (state == S_EMIT && job_ready)) && !last_hand)
            hand_idx <= hand_e'(hand_idx + 2'd1);
      end
   end

endmodule

// File: tb/tb_clock_hand_scheduler.sv
// Directed bench for clock_hand_scheduler: nominal frame, backpressure, timeout,
// overrun with snapshot hold, reset abort, and the angle boundary cases.
module tb_clock_hand_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        slow_clk;
   logic [3:0]  hour;
   logic [5:0]  minute;
   logic [5:0]  second;
   logic [3:0]  al_hour;
   logic [5:0]  al_minute;
   logic        cordic_start;
   logic [15:0] cordic_angle;
   logic        cordic_done;
   logic [15:0] sin_in;
   logic [15:0] cos_in;
   logic        clr_req;
   logic        clr_ack;
   logic        job_valid;
   logic        job_ready;
   logic [1:0]  job_hand;
   logic [4:0]  job_len;
   logic [15:0] job_sin;
   logic [15:0] job_cos;
   logic        busy;
   logic        frame_done;
   logic        overrun;
   logic        timeout_err;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   int fd_cnt    = 0;
   int xfer_cnt  = 0;
   int start_cnt = 0;
   int ovr_cnt   = 0;

   clock_hand_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .slow_clk     (slow_clk),
      .hour         (hour),
      .minute       (minute),
      .second       (second),
      .al_hour      (al_hour),
      .al_minute    (al_minute),
      .cordic_start (cordic_start),
      .cordic_angle (cordic_angle),
      .cordic_done  (cordic_done),
      .sin_in       (sin_in),
      .cos_in       (cos_in),
      .clr_req      (clr_req),
      .clr_ack      (clr_ack),
      .job_valid    (job_valid),
      .job_ready    (job_ready),
      .job_hand     (job_hand),
      .job_len      (job_len),
      .job_sin      (job_sin),
      .job_cos      (job_cos),
      .busy         (busy),
      .frame_done   (frame_done),
      .overrun      (overrun),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   // Event counters sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (frame_done)             fd_cnt    <= fd_cnt + 1;
      if (job_valid && job_ready) xfer_cnt  <= xfer_cnt + 1;
      if (cordic_start)           start_cnt <= start_cnt + 1;
      if (overrun)                ovr_cnt   <= ovr_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic any_output();
      return |{cordic_start, cordic_angle, clr_req, job_valid, job_hand, job_len,
               job_sin, job_cos, busy, frame_done, overrun, timeout_err};
   endfunction

   // Entered with the hand's cordic_start visible; leaves with its job_valid visible.
   task automatic do_hand(input int h, input int ang, input int len, input int lat,
                          input logic [15:0] s, input logic [15:0] c);
      check($sformatf("h%0d_start", h), 32'(cordic_start), 1);
      check($sformatf("h%0d_angle", h), 32'(cordic_angle), ang);
      tick();
      check($sformatf("h%0d_start_pulse", h), 32'(cordic_start), 0);
      for (int i = 1; i < lat; i++) tick();
      check($sformatf("h%0d_angle_hold", h), 32'(cordic_angle), ang);
      cordic_done = 1'b1;
      sin_in      = s;
      cos_in      = c;
      tick();
      cordic_done = 1'b0;
      sin_in      = 16'hdead;
      cos_in      = 16'hbeef;
      check($sformatf("h%0d_valid", h), 32'(job_valid), 1);
      check($sformatf("h%0d_hand", h), 32'(job_hand), h);
      check($sformatf("h%0d_len", h), 32'(job_len), len);
      check($sformatf("h%0d_sin", h), 32'(job_sin), 32'(s));
      check($sformatf("h%0d_cos", h), 32'(job_cos), 32'(c));
   endtask

   initial begin
      int sc0;
      int x0;
      int f0;
      int o0;

      reset       = 1'b1;
      slow_clk    = 1'b0;
      hour        = 4'd3;
      minute      = 6'd30;
      second      = 6'd15;
      al_hour     = 4'd7;
      al_minute   = 6'd40;
      cordic_done = 1'b0;
      sin_in      = 16'd0;
      cos_in      = 16'd0;
      clr_ack     = 1'b0;
      job_ready   = 1'b1;

      // Reset state
      repeat (3) tick();
      check("reset_outputs", 32'(any_output()), 0);
      reset = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 0);

      // Nominal frame 3:30:15, alarm 7:40
      slow_clk = 1'b1;
      tick();
      check("n_clr_req", 32'(clr_req), 1);
      check("n_busy", 32'(busy), 1);
      slow_clk = 1'b0;
      tick();
      check("n_clr_hold", 32'(clr_req), 1);
      check("n_no_start", 32'(cordic_start), 0);
      clr_ack = 1'b1;
      tick();
      clr_ack = 1'b0;
      do_hand(0, 105, 23, 16, 16'h2d41, 16'h1111);
      tick();
      do_hand(1, 180, 31, 16, 16'h0000, 16'hc000);
      tick();
      do_hand(2, 90, 27, 16, 16'h4000, 16'h0000);
      tick();
      do_hand(3, 234, 17, 16, 16'hcc3b, 16'hdb1f);
      tick();
      check("n_frame_done", 32'(frame_done), 1);
      check("n_busy_finish", 32'(busy), 1);
      tick();
      check("n_frame_done_pulse", 32'(frame_done), 0);
      check("n_busy_low", 32'(busy), 0);
      check("n_frame_count", 32'(fd_cnt), 1);
      check("n_xfer_count", 32'(xfer_cnt), 4);

      // Back-to-back trigger, boundary angles, backpressure on hand 1
      hour      = 4'd12;
      minute    = 6'd0;
      second    = 6'd60;
      al_hour   = 4'd11;
      al_minute = 6'd59;
      slow_clk  = 1'b1;
      tick();
      check("b_clr_req", 32'(clr_req), 1);
      slow_clk = 1'b0;
      clr_ack  = 1'b1;
      tick();
      clr_ack = 1'b0;
      do_hand(0, 0, 23, 4, 16'h0123, 16'h4567);
      tick();
      job_ready = 1'b0;
      do_hand(1, 0, 31, 4, 16'h89ab, 16'hcdef);
      sc0 = start_cnt;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_valid", 32'(job_valid), 1);
         check("bp_sin", 32'(job_sin), 32'h89ab);
         check("bp_cos", 32'(job_cos), 32'hcdef);
         check("bp_no_start", 32'(cordic_start), 0);
      end
      job_ready = 1'b1;
      tick();
      check("bp_start_after_xfer", 32'(cordic_start), 1);
      check("bp_start_count", 32'(start_cnt), 32'(sc0));
      check("bp_valid_drop", 32'(job_valid), 0);
      do_hand(2, 354, 27, 4, 16'h1357, 16'h2468);
      tick();
      do_hand(3, 360, 17, 4, 16'h7fff, 16'h8001);
      tick();
      check("b_frame_done", 32'(frame_done), 1);
      tick();

      // Timeout on hand 1; hour 15 and minute 63 exercise reduction and clamping
      hour      = 4'd15;
      minute    = 6'd63;
      second    = 6'd45;
      al_hour   = 4'd2;
      al_minute = 6'd25;
      slow_clk  = 1'b1;
      tick();
      check("t_clr_req", 32'(clr_req), 1);
      slow_clk = 1'b0;
      clr_ack  = 1'b1;
      tick();
      clr_ack = 1'b0;
      do_hand(0, 119, 23, 8, 16'h0a0a, 16'h0b0b);
      tick();
      check("t_h1_start", 32'(cordic_start), 1);
      check("t_h1_angle", 32'(cordic_angle), 354);
      x0 = xfer_cnt;
      repeat (64) tick();
      check("t_err_not_yet", 32'(timeout_err), 0);
      check("t_no_job", 32'(job_valid), 0);
      check("t_still_waiting", 32'(cordic_start), 0);
      tick();
      check("t_err_set", 32'(timeout_err), 1);
      do_hand(2, 270, 27, 8, 16'h0c0c, 16'h0d0d);
      tick();
      do_hand(3, 72, 17, 8, 16'h0e0e, 16'h0f0f);
      tick();
      check("t_frame_done", 32'(frame_done), 1);
      check("t_two_jobs", 32'(xfer_cnt - x0), 2);
      tick();

      // Overrun during WAIT; inputs changed after the snapshot
      hour      = 4'd3;
      minute    = 6'd30;
      second    = 6'd15;
      al_hour   = 4'd7;
      al_minute = 6'd40;
      o0        = ovr_cnt;
      slow_clk  = 1'b1;
      tick();
      check("o_clr_req", 32'(clr_req), 1);
      slow_clk = 1'b0;
      second   = 6'd16;
      hour     = 4'd9;
      clr_ack  = 1'b1;
      tick();
      clr_ack = 1'b0;
      check("o_h0_start", 32'(cordic_start), 1);
      check("o_h0_angle", 32'(cordic_angle), 105);
      tick();
      slow_clk = 1'b1;
      tick();
      check("o_overrun", 32'(overrun), 1);
      check("o_no_restart", 32'(clr_req), 0);
      tick();
      check("o_overrun_pulse", 32'(overrun), 0);
      check("o_busy", 32'(busy), 1);
      slow_clk    = 1'b0;
      cordic_done = 1'b1;
      sin_in      = 16'h1234;
      cos_in      = 16'h5678;
      tick();
      cordic_done = 1'b0;
      check("o_h0_valid", 32'(job_valid), 1);
      check("o_h0_sin", 32'(job_sin), 32'h1234);
      tick();
      do_hand(1, 180, 31, 3, 16'h1111, 16'h2222);
      tick();
      do_hand(2, 90, 27, 3, 16'h3333, 16'h4444);
      tick();
      do_hand(3, 234, 17, 3, 16'h5555, 16'h6666);
      tick();
      check("o_frame_done", 32'(frame_done), 1);
      check("o_overrun_count", 32'(ovr_cnt - o0), 1);
      check("o_err_sticky", 32'(timeout_err), 1);
      tick();

      // Reset during WAIT with the tick held high through release
      slow_clk = 1'b1;
      tick();
      check("r_clr_req", 32'(clr_req), 1);
      clr_ack = 1'b1;
      tick();
      clr_ack = 1'b0;
      tick();
      tick();
      check("r_in_wait", 32'(busy), 1);
      f0    = fd_cnt;
      x0    = xfer_cnt;
      reset = 1'b1;
      tick();
      check("r_outputs_zero", 32'(any_output()), 0);
      check("r_busy_zero", 32'(busy), 0);
      tick();
      reset = 1'b0;
      tick();
      tick();
      check("r_no_trigger", 32'(clr_req), 0);
      check("r_idle", 32'(busy), 0);
      check("r_err_cleared", 32'(timeout_err), 0);
      check("r_no_frame_done", 32'(fd_cnt), 32'(f0));
      check("r_no_job", 32'(xfer_cnt), 32'(x0));
      slow_clk = 1'b0;
      tick();
      check("r_low_idle", 32'(busy), 0);
      slow_clk = 1'b1;
      tick();
      check("r_retrigger", 32'(clr_req), 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
